// File: rtl/fpu_mul_pipe.sv
// fpu_mul_pipe: three-stage IEEE-754 multiplier with RNE rounding, flush-to-zero and exception flags
module fpu_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_result,
  output logic [4:0]             out_flags
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * MAN_W + 2;
  localparam logic [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};
  typedef struct packed {
    logic             v;
    logic             s;
    logic             sp;
    logic [W-1:0]     spr;
    logic [4:0]       spf;
    logic [EW-1:0]    e;
    logic [MAN_W:0]   ma;
    logic [MAN_W:0]   mb;
  } st1_t;
  typedef struct packed {
    logic             v;
    logic             s;
    logic             sp;
    logic [W-1:0]     spr;
    logic [4:0]       spf;
    logic [EW-1:0]    e;
    logic [PW-1:0]    p;
  } st2_t;
  typedef struct packed {
    logic             v;
    logic [W-1:0]     res;
    logic [4:0]       flg;
  } st3_t;
  st1_t s1_d, s1_q;
  st2_t s2_d, s2_q;
  st3_t s3_d, s3_q;
  logic adv;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic sg, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, inv0;
  logic [PW-1:0] pn;
  logic [MAN_W:0] mant;
  logic [MAN_W+1:0] mr;
  logic [MAN_W-1:0] frac;
  logic [EW-1:0] en, ef;
  logic g, r, st, up, cy, ovf, unf;
  assign adv = !(s3_q.v && !out_ready);
  assign in_ready = adv;
  assign out_valid = s3_q.v;
  assign out_result = s3_q.res;
  assign out_flags = s3_q.flg;
  always_comb begin
    ea = in_a[W-2:MAN_W];
    eb = in_b[W-2:MAN_W];
    fa = in_a[MAN_W-1:0];
    fb = in_b[MAN_W-1:0];
    sg = in_a[W-1] ^ in_b[W-1];
    nan_a = (&ea) && (|fa);
    nan_b = (&eb) && (|fb);
    inf_a = (&ea) && !(|fa);
    inf_b = (&eb) && !(|fb);
    zero_a = ~|ea;
    zero_b = ~|eb;
    inv0 = (inf_a && zero_b) || (zero_a && inf_b);
    s1_d = s1_q;
    if (adv) begin
      s1_d.v = in_valid;
      s1_d.s = sg;
      s1_d.sp = nan_a || nan_b || inf_a || inf_b || zero_a || zero_b;
      s1_d.spr = (nan_a || nan_b || inv0) ? QNAN :
                 (inf_a || inf_b) ? {sg, {EXP_W{1'b1}}, {MAN_W{1'b0}}} : {sg, {(W - 1){1'b0}}};
      s1_d.spf = {(nan_a && !fa[MAN_W-1]) || (nan_b && !fb[MAN_W-1]) || inv0, 4'b0};
      s1_d.e = {2'b0, ea} + {2'b0, eb} - BIAS;
      s1_d.ma = {1'b1, fa};
      s1_d.mb = {1'b1, fb};
    end
  end
  always_comb begin
    s2_d = s2_q;
    if (adv) begin
      s2_d.v = s1_q.v;
      s2_d.s = s1_q.s;
      s2_d.sp = s1_q.sp;
      s2_d.spr = s1_q.spr;
      s2_d.spf = s1_q.spf;
      s2_d.e = s1_q.e;
      s2_d.p = PW'(s1_q.ma) * PW'(s1_q.mb);
    end
  end
  always_comb begin
    pn = s2_q.p[PW-1] ? s2_q.p : s2_q.p << 1;
    en = s2_q.e + EW'(s2_q.p[PW-1]);
    mant = pn[PW-1:MAN_W+1];
    g = pn[MAN_W];
    r = pn[MAN_W-1];
    st = |pn[MAN_W-2:0];
    up = g && (r || st || mant[0]);
    mr = {1'b0, mant} + (MAN_W + 2)'(up);
    cy = mr[MAN_W+1];
    frac = cy ? mr[MAN_W:1] : mr[MAN_W-1:0];
    ef = en + EW'(cy);
    ovf = !ef[EW-1] && ef >= EMAX;
    unf = ef[EW-1] || ef == '0;
    s3_d = s3_q;
    if (adv) begin
      s3_d.v = s2_q.v;
      s3_d.res = s2_q.sp ? s2_q.spr :
                 ovf ? {s2_q.s, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
                 unf ? {s2_q.s, {(W - 1){1'b0}}} : {s2_q.s, ef[EXP_W-1:0], frac};
      s3_d.flg = s2_q.sp ? s2_q.spf : ovf ? 5'b00101 : unf ? 5'b00011 : {4'b0, g | r | st};
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end
endmodule
